// File: rtl/block_engine_scheduler_if.sv
// Requester, response and engine signals shared between the scheduler and its
// environment. The slave modport is the scheduler side.
interface block_engine_scheduler_if #(
    parameter int WSIZE = 32,
    parameter int BSIZE = WSIZE * 4
);
    logic [1:0]         req_valid;
    logic [2*WSIZE-1:0] req_word;
    logic [1:0]         req_accept;
    logic [WSIZE-1:0]   rsp_word;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_hold;
    logic [BSIZE-1:0]   eng_block_out;
    logic               eng_start;
    logic               eng_busy;
    logic               eng_done;
    logic [BSIZE-1:0]   eng_block_in;
    logic               grant;
    logic               sched_busy;

    modport master (
        output req_valid, req_word, rsp_hold, eng_busy, eng_done, eng_block_in,
        input  req_accept, rsp_word, rsp_valid, eng_block_out, eng_start, grant, sched_busy
    );

    modport slave (
        input  req_valid, req_word, rsp_hold, eng_busy, eng_done, eng_block_in,
        output req_accept, rsp_word, rsp_valid, eng_block_out, eng_start, grant, sched_busy
    );
endinterface

// File: rtl/block_engine_scheduler.sv
// Two-requester scheduler: gathers four words from the granted requester into a
// block, launches the shared engine, and drains the result block back word by word.
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters
// GATHER | accept four words from the granted requester
// ISSUE  | wait for engine not busy, pulse eng_start
// WAIT   | wait for eng_done, capture result block
// DRAIN  | return four result words, honouring rsp_hold
module block_engine_scheduler #(
    parameter int WSIZE = 32,
    parameter int BSIZE = WSIZE * 4
) (
    input  logic                   clock,
    input  logic                   reset,
    block_engine_scheduler_if.slave bus_if
);
    typedef enum logic [2:0] {IDLE, GATHER, ISSUE, WAIT, DRAIN} state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic [1:0]       count_q, count_d;
    logic [BSIZE-1:0] block_q, block_d;
    logic [BSIZE-1:0] result_q, result_d;
    logic [WSIZE-1:0] rsp_word_q, rsp_word_d;

    logic [WSIZE-1:0] gather_word;
    logic [WSIZE-1:0] drain_word;
    logic [1:0]       req_accept;
    logic [1:0]       rsp_valid;
    logic             eng_start;

    always_comb begin
        gather_word = grant_q ? bus_if.req_word[2*WSIZE-1 -: WSIZE] : bus_if.req_word[WSIZE-1:0];
    end

    // Word 0 sits in the most significant slot, both for gather and drain.
    always_comb begin
        drain_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (count_q == 2'(k)) drain_word = result_q[BSIZE-1-k*WSIZE -: WSIZE];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        block_d      = block_q;
        result_d     = result_q;
        rsp_word_d   = rsp_word_q;
        req_accept   = '0;
        rsp_valid    = '0;
        eng_start    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus_if.req_valid) begin
                    grant_d = (&bus_if.req_valid) ? ~last_grant_q : bus_if.req_valid[1];
                    state_d = GATHER;
                end
            end
            GATHER: begin
                req_accept[grant_q] = bus_if.req_valid[grant_q];
                if (bus_if.req_valid[grant_q]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (count_q == 2'(k)) block_d[BSIZE-1-k*WSIZE -: WSIZE] = gather_word;
                    end
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) state_d = ISSUE;
                end
            end
            ISSUE: begin
                eng_start = ~bus_if.eng_busy;
                if (!bus_if.eng_busy) state_d = WAIT;
            end
            WAIT: begin
                if (bus_if.eng_done) begin
                    result_d = bus_if.eng_block_in;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                rsp_valid[grant_q] = 1'b1;
                rsp_word_d         = drain_word;
                if (!bus_if.rsp_hold[grant_q]) begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= 2'd0;
            block_q      <= '0;
            result_q     <= '0;
            rsp_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            block_q      <= block_d;
            result_q     <= result_d;
            rsp_word_q   <= rsp_word_d;
        end
    end

    // Outside DRAIN the last word shown stays on the shared response bus.
    assign bus_if.rsp_word      = (state_q == DRAIN) ? drain_word : rsp_word_q;
    assign bus_if.req_accept    = req_accept;
    assign bus_if.rsp_valid     = rsp_valid;
    assign bus_if.eng_start     = eng_start;
    assign bus_if.eng_block_out = block_q;
    assign bus_if.grant         = grant_q;
    assign bus_if.sched_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_block_engine_scheduler.sv
// Self-checking bench for block_engine_scheduler: directed vector table plus
// randomized transactions against a phase-level reference model.
module tb_block_engine_scheduler;
    localparam int WSIZE = 32;
    localparam int BSIZE = 128;

    localparam int P_IDLE   = 0;
    localparam int P_GATHER = 1;
    localparam int P_ISSUE  = 2;
    localparam int P_WAIT   = 3;
    localparam int P_DRAIN  = 4;
    localparam int P_END    = 5;

    typedef logic [BSIZE-1:0] blk_t;

    typedef struct {
        logic [1:0] pend;
        int         drop_after;
        int         drop_len;
        int         busy_len;
        int         hold_at;
        int         hold_len;
        bit         spurious;
        bit         abort;
        bit         fixed;
        int         exp_grant;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    block_engine_scheduler_if #(.WSIZE(WSIZE), .BSIZE(BSIZE)) bus();

    block_engine_scheduler #(.WSIZE(WSIZE), .BSIZE(BSIZE)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus_if (bus)
    );

    int               n_cmp  = 0;
    int               n_fail = 0;
    int               last_grant_m;
    logic [WSIZE-1:0] last_rsp_m;
    logic [WSIZE-1:0] words [2][4];
    vec_t             tbl [8];

    task automatic check(input string name, input blk_t act, input blk_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid    = 2'b00;
        bus.req_word     = '0;
        bus.rsp_hold     = 2'b00;
        bus.eng_busy     = 1'b0;
        bus.eng_done     = 1'b0;
        bus.eng_block_in = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sched_busy"}, blk_t'(bus.sched_busy), blk_t'(0));
        check({tag, "_rsp_valid"}, blk_t'(bus.rsp_valid), blk_t'(0));
        check({tag, "_req_accept"}, blk_t'(bus.req_accept), blk_t'(0));
        check({tag, "_eng_start"}, blk_t'(bus.eng_start), blk_t'(0));
        check({tag, "_eng_block_out"}, blk_t'(bus.eng_block_out), blk_t'(0));
        check({tag, "_rsp_word"}, blk_t'(bus.rsp_word), blk_t'(0));
        check({tag, "_grant"}, blk_t'(bus.grant), blk_t'(0));
    endtask

    // One full transaction, entered at posedge+1 with the DUT idle.
    task automatic run_txn(input vec_t v);
        int               g, ph, sent, stall, busy_left, done_cnt, got, hold_cnt, starts_seen;
        blk_t             exp_block, exp_res;
        logic             vg, dn, hg, busy;
        logic [WSIZE-1:0] wg;
        g = (v.exp_grant >= 0) ? v.exp_grant :
            ((v.pend == 2'b11) ? 1 - last_grant_m : (v.pend[1] ? 1 : 0));
        for (int k = 0; k < 4; k++) begin
            words[0][k] = $urandom;
            words[1][k] = $urandom;
            if (v.fixed) words[g][k] = 32'h1111_1111 * (k + 1);
        end
        exp_block = {words[g][0], words[g][1], words[g][2], words[g][3]};
        exp_res   = v.fixed ? {4{32'hAAAA_AAAA}}
                            : ({exp_block[63:0], exp_block[127:64]} ^ {4{32'hA5A5_5A5A}});
        ph = P_IDLE; sent = 0; stall = 0; busy_left = v.busy_len; done_cnt = 0;
        got = 0; hold_cnt = 0; starts_seen = 0;
        for (int cyc = 0; cyc < 300 && ph != P_END; cyc++) begin
            if (ph == P_IDLE) vg = 1'b1;
            else if (ph == P_GATHER) vg = !(sent == v.drop_after && stall < v.drop_len);
            else vg = 1'b0;
            busy = (ph == P_ISSUE) && (busy_left > 0);
            dn   = (ph == P_WAIT && done_cnt == 0) ||
                   (v.spurious && (ph == P_IDLE || (ph == P_GATHER && sent == 1)));
            hg   = (ph == P_DRAIN) && (got == v.hold_at) && (hold_cnt < v.hold_len);
            wg   = words[g][(sent < 4) ? sent : 3];
            bus.req_valid    = v.pend;
            bus.req_valid[g] = vg;
            bus.req_word     = (g == 0) ? {words[1][0], wg} : {wg, words[0][0]};
            bus.eng_busy     = busy;
            bus.eng_done     = dn;
            bus.eng_block_in = (ph == P_WAIT) ? exp_res : ~exp_res;
            bus.rsp_hold     = 2'($urandom_range(0, 3));
            bus.rsp_hold[g]  = hg;
            if (v.abort && ph == P_WAIT) begin
                bus.eng_done = 1'b0;
                #1;
                check("abort_grant_before", blk_t'(bus.grant), blk_t'(g));
                reset = 1'b1;
                #1;
                check_reset_outputs("abort_async");
                bus.req_valid = 2'b00;
                @(posedge clock); #1;
                reset = 1'b0;
                bus.eng_done     = 1'b1;
                bus.eng_block_in = exp_res;
                #1;
                check("abort_done_busy", blk_t'(bus.sched_busy), blk_t'(0));
                @(posedge clock); #1;
                bus.eng_done = 1'b0;
                #1;
                check("abort_after_busy", blk_t'(bus.sched_busy), blk_t'(0));
                check("abort_after_rsp_valid", blk_t'(bus.rsp_valid), blk_t'(0));
                check("abort_after_rsp_word", blk_t'(bus.rsp_word), blk_t'(0));
                check("abort_after_block", blk_t'(bus.eng_block_out), blk_t'(0));
                last_grant_m = 1;
                last_rsp_m   = '0;
                drive_idle();
                @(posedge clock); #1;
                return;
            end
            #1;
            check("req_accept", blk_t'(bus.req_accept),
                  blk_t'((ph == P_GATHER && vg) ? (2'b01 << g) : 2'b00));
            check("eng_start", blk_t'(bus.eng_start), blk_t'(ph == P_ISSUE && !busy));
            check("sched_busy", blk_t'(bus.sched_busy), blk_t'(ph != P_IDLE));
            check("rsp_valid", blk_t'(bus.rsp_valid),
                  blk_t'((ph == P_DRAIN) ? (2'b01 << g) : 2'b00));
            if (ph != P_IDLE) check("grant", blk_t'(bus.grant), blk_t'(g));
            if (ph == P_ISSUE || ph == P_WAIT)
                check("eng_block_out", bus.eng_block_out, exp_block);
            if (ph == P_DRAIN)
                check("rsp_word", blk_t'(bus.rsp_word), blk_t'(exp_res[BSIZE-1-got*WSIZE -: WSIZE]));
            else
                check("rsp_word_held", blk_t'(bus.rsp_word), blk_t'(last_rsp_m));
            if (bus.eng_start) starts_seen++;
            case (ph)
                P_IDLE:   ph = P_GATHER;
                P_GATHER: begin
                    if (vg) begin
                        sent++;
                        if (sent == 4) ph = P_ISSUE;
                    end else stall++;
                end
                P_ISSUE:  begin
                    if (!busy) begin
                        ph = P_WAIT;
                        done_cnt = 2;
                    end else busy_left--;
                end
                P_WAIT:   begin
                    if (dn) ph = P_DRAIN;
                    else done_cnt--;
                end
                P_DRAIN:  begin
                    last_rsp_m = exp_res[BSIZE-1-got*WSIZE -: WSIZE];
                    if (!hg) begin
                        got++;
                        if (got == 4) ph = P_END;
                    end else hold_cnt++;
                end
                default:  ph = P_END;
            endcase
            @(posedge clock); #1;
        end
        check("txn_completed", blk_t'(ph == P_END), blk_t'(1));
        check("eng_start_pulses", blk_t'(starts_seen), blk_t'(1));
        last_grant_m = g;
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // pend, drop_after, drop_len, busy_len, hold_at, hold_len, spurious, abort, fixed, exp_grant
        tbl[0] = '{2'b11, -1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{2'b11, -1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{2'b01, -1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{2'b01,  2, 3, 0,  1, 2, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{2'b10, -1, 0, 5, -1, 0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5] = '{2'b11,  1, 2, 1,  3, 1, 1'b1, 1'b0, 1'b0, 0};
        tbl[6] = '{2'b10, -1, 0, 2, -1, 0, 1'b0, 1'b1, 1'b0, 1};
        tbl[7] = '{2'b11, -1, 0, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0};

        drive_idle();
        reset = 1'b1;
        bus.req_valid = 2'b11;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        last_grant_m = 1;
        last_rsp_m   = '0;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            vec_t r;
            r.pend       = 2'($urandom_range(1, 3));
            r.drop_after = $urandom_range(0, 4);
            r.drop_len   = $urandom_range(0, 3);
            r.busy_len   = $urandom_range(0, 3);
            r.hold_at    = $urandom_range(0, 3);
            r.hold_len   = $urandom_range(0, 3);
            r.spurious   = 1'($urandom_range(0, 1));
            r.abort      = ($urandom_range(0, 9) == 0);
            r.fixed      = 1'b0;
            r.exp_grant  = -1;
            run_txn(r);
        end

        #1;
        check("final_sched_busy", blk_t'(bus.sched_busy), blk_t'(0));
        check("final_rsp_word", blk_t'(bus.rsp_word), blk_t'(last_rsp_m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
